// File: rtl/ct_idu_fence_pkg.sv
// Shared state encoding, fence-type bit positions and defaults for the ID fence sequencer.
package ct_idu_fence_pkg;

    typedef enum logic [2:0] {
        FSEQ_IDLE    = 3'd0,
        FSEQ_DRAIN   = 3'd1,
        FSEQ_ISSUE   = 3'd2,
        FSEQ_WAIT    = 3'd3,
        FSEQ_REFETCH = 3'd4
    } fseq_state_e;

    localparam int FT_SYNC   = 0;
    localparam int FT_CP0    = 1;
    localparam int FT_IFENCE = 2;

    localparam int DRAIN_HOLD_DEF = 2;
    localparam int HOLD_CNT_W     = 3;

    // A fence decoded with no type bits still needs full serialisation, so treat it as CP0.
    function automatic logic [2:0] fence_type_norm(input logic [2:0] t);
        fence_type_norm = (t == 3'b000) ? 3'(1 << FT_CP0) : t;
    endfunction

endpackage

// File: rtl/ct_idu_fence_drain_cnt.sv
// Saturating count of consecutive ROB-empty cycles; cleared whenever not enabled or ROB not empty.
module ct_idu_fence_drain_cnt
    import ct_idu_fence_pkg::*;
#(
    parameter int HOLD = DRAIN_HOLD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rob_empty,
    output logic hit
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_V = HOLD_CNT_W'(HOLD);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && rob_empty) begin
            cnt_d = (cnt_q == HOLD_V) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Look at the next value so the sequencer leaves DRAIN on the cycle the hold is met.
    assign hit = en && (cnt_d == HOLD_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ct_idu_id_fence_seq.sv
// ID-stage fence sequencer: stall, drain, issue alone, wait retire, optional refetch.
// Optional watchdog enabled by defining CT_IDU_FENCE_TIMEOUT_EN.
module ct_idu_id_fence_seq
    import ct_idu_fence_pkg::*;
#(
    parameter int DRAIN_HOLD = DRAIN_HOLD_DEF,
    parameter int TMO_W      = 10
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst_b,
    input  logic       id_inst_vld,
    input  logic       id_fence,
    input  logic [2:0] id_fence_type,
    input  logic       rtu_idu_rob_empty,
    input  logic       rtu_yy_xx_flush,
    input  logic       ir_fence_rdy,
    input  logic       rtu_idu_fence_cmplt,
    output logic       idu_id_stall,
    output logic       idu_ir_fence_vld,
    output logic [2:0] idu_ir_fence_type,
    output logic       idu_ifu_refetch,
    output logic       fence_seq_busy,
    output logic       fence_seq_tmo
);

    if (DRAIN_HOLD < 1 || DRAIN_HOLD > 7 || TMO_W < 1) begin : g_param_chk
        $error("ct_idu_id_fence_seq: parameter out of range");
    end

    fseq_state_e state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic        ret_q, ret_d;
    logic        capture;
    logic        drain_en;
    logic        drain_hit;

    // ret_q marks the first IDLE cycle after a sequence so a waiting fence is not captured back-to-back.
    assign capture  = (state_q == FSEQ_IDLE) && !ret_q && !rtu_yy_xx_flush && id_inst_vld && id_fence;
    assign drain_en = (state_q == FSEQ_DRAIN) && !rtu_yy_xx_flush;

    ct_idu_fence_drain_cnt #(
        .HOLD (DRAIN_HOLD)
    ) u_drain_cnt (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .en        (drain_en),
        .rob_empty (rtu_idu_rob_empty),
        .hit       (drain_hit)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        unique case (state_q)
            FSEQ_IDLE: begin
                if (capture) begin
                    state_d = FSEQ_DRAIN;
                    type_d  = fence_type_norm(id_fence_type);
                end
            end
            FSEQ_DRAIN:   if (drain_hit) state_d = FSEQ_ISSUE;
            FSEQ_ISSUE:   if (ir_fence_rdy) state_d = FSEQ_WAIT;
            FSEQ_WAIT: begin
                if (rtu_idu_fence_cmplt) begin
                    state_d = type_q[FT_IFENCE] ? FSEQ_REFETCH : FSEQ_IDLE;
                end
            end
            FSEQ_REFETCH: state_d = FSEQ_IDLE;
            default:      state_d = FSEQ_IDLE;
        endcase
        if (rtu_yy_xx_flush) begin
            state_d = FSEQ_IDLE;
        end
        if (state_d == FSEQ_IDLE) begin
            type_d = '0;
        end
        ret_d = (state_q != FSEQ_IDLE) && (state_d == FSEQ_IDLE);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= FSEQ_IDLE;
            type_q  <= '0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            ret_q   <= ret_d;
        end
    end

    assign idu_id_stall      = (state_q != FSEQ_IDLE) || (id_inst_vld && id_fence);
    assign idu_ir_fence_vld  = (state_q == FSEQ_ISSUE);
    assign idu_ir_fence_type = type_q;
    assign idu_ifu_refetch   = (state_q == FSEQ_REFETCH);
    assign fence_seq_busy    = (state_q != FSEQ_IDLE);

`ifdef CT_IDU_FENCE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;
    logic             tmo_run;

    // Counting only while staying in DRAIN/WAIT gives the clear-on-entry behaviour for free.
    assign tmo_run = ((state_q == FSEQ_DRAIN) || (state_q == FSEQ_WAIT)) && (state_d == state_q);

    always_comb begin
        tmo_cnt_d = '0;
        if (tmo_run) begin
            tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
        tmo_d = !rtu_yy_xx_flush && (tmo_q || (&tmo_cnt_q));
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign fence_seq_tmo = tmo_q;
`else
    assign fence_seq_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_ct_idu_id_fence_seq.sv
// Directed bench for ct_idu_id_fence_seq with a transaction-level reference model and per-cycle compare.
module tb_ct_idu_id_fence_seq;
  import ct_idu_fence_pkg::*;

`ifdef CT_IDU_FENCE_TIMEOUT_EN
  localparam int TB_TMO_W = 4;
`else
  localparam int TB_TMO_W = 10;
`endif
  localparam int HOLD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_inst_vld, id_fence, rob_empty, flush, rdy, cmplt;
  logic [2:0] id_fence_type;
  logic       stall, fvld, refetch, busy, tmo;
  logic [2:0] ftype;

  ct_idu_id_fence_seq #(
    .DRAIN_HOLD (HOLD),
    .TMO_W      (TB_TMO_W)
  ) dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_n),
    .id_inst_vld         (id_inst_vld),
    .id_fence            (id_fence),
    .id_fence_type       (id_fence_type),
    .rtu_idu_rob_empty   (rob_empty),
    .rtu_yy_xx_flush     (flush),
    .ir_fence_rdy        (rdy),
    .rtu_idu_fence_cmplt (cmplt),
    .idu_id_stall        (stall),
    .idu_ir_fence_vld    (fvld),
    .idu_ir_fence_type   (ftype),
    .idu_ifu_refetch     (refetch),
    .fence_seq_busy      (busy),
    .fence_seq_tmo       (tmo)
  );

  int total = 0;
  int bad = 0;
  int refetch_pulses = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One fence in flight: draining -> issuing -> waiting -> (refetching) -> done.
  bit         m_busy, m_issue, m_wait, m_refetch, m_hold_off, m_was_busy;
  int         m_run;
  logic [2:0] m_type;

  task automatic model_clear();
    m_busy = 0; m_issue = 0; m_wait = 0; m_refetch = 0;
    m_run = 0; m_type = 3'b000; m_hold_off = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      m_was_busy = m_busy;
      if (flush) begin
        model_clear();
        m_hold_off = m_was_busy;
      end else if (!m_busy) begin
        if (id_inst_vld && id_fence && !m_hold_off) begin
          m_busy = 1;
          m_run  = 0;
          m_type = (id_fence_type == 3'b000) ? 3'b010 : id_fence_type;
        end
        m_hold_off = 0;
      end else if (m_refetch) begin
        model_clear();
        m_hold_off = 1;
      end else if (m_wait) begin
        if (cmplt) begin
          if (m_type[2]) begin
            m_wait = 0;
            m_refetch = 1;
          end else begin
            model_clear();
            m_hold_off = 1;
          end
        end
      end else if (m_issue) begin
        if (rdy) begin
          m_issue = 0;
          m_wait = 1;
        end
      end else begin
        m_run = rob_empty ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
        if (m_run >= HOLD) m_issue = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk1("stall", stall, m_busy || (id_inst_vld && id_fence));
    chk1("fence_vld", fvld, m_issue);
    chk3("fence_type", ftype, m_type);
    chk1("refetch", refetch, m_refetch);
    chk1("busy", busy, m_busy);
`ifndef CT_IDU_FENCE_TIMEOUT_EN
    chk1("tmo_tied", tmo, 1'b0);
`endif
    if (refetch === 1'b1) refetch_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic f, input logic [2:0] t,
                        input logic rob, input logic r, input logic cm, input logic fl);
    id_inst_vld = v; id_fence = f; id_fence_type = t;
    rob_empty = rob; rdy = r; cmplt = cm; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From the first DRAIN cycle with ROB empty and IR ready: 2 drain, 1 issue, then pulse cmplt in WAIT.
  task automatic drain_issue_cmplt();
    set_in(0, 0, 3'b000, 1, 1, 0, 0);
    cyc(); cyc(); cyc();
    set_in(0, 0, 3'b000, 1, 1, 1, 0);
    cyc();
    set_in(0, 0, 3'b000, 1, 1, 0, 0);
  endtask

  int rp0;

  initial begin
    set_in(0, 0, 3'b000, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_vld", fvld, 1'b0);
    chk3("rst_type", ftype, 3'b000);
    chk1("rst_refetch", refetch, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tmo", tmo, 1'b0);
    rst_n = 1'b1;
    cyc();

    // CP0 fence: two drain cycles, one issue cycle, no refetch
    set_in(1, 1, 3'b010, 0, 1, 0, 0);
    #2 chk1("s1_cap_stall", stall, 1'b1); chk1("s1_cap_busy", busy, 1'b0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    #2 chk1("s1_d1_busy", busy, 1'b1); chk1("s1_d1_vld", fvld, 1'b0);
    cyc(); #2 chk1("s1_d2_vld", fvld, 1'b0);
    cyc(); #2 chk1("s1_iss_vld", fvld, 1'b1); chk3("s1_iss_type", ftype, 3'b010);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 1, 0);
    #2 chk1("s1_wait_vld", fvld, 1'b0); chk1("s1_wait_stall", stall, 1'b1);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    #2 chk1("s1_idle_stall", stall, 1'b0); chk1("s1_idle_refetch", refetch, 1'b0);
    cyc();

    // fence.i: refetch pulse, then a fence waiting on the return cycle is taken one cycle later
    rp0 = refetch_pulses;
    set_in(1, 1, 3'b100, 1, 1, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    cyc(); cyc();
    #2 chk1("s2_iss_vld", fvld, 1'b1); chk3("s2_iss_type", ftype, 3'b100);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 1, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    #2 chk1("s2_refetch", refetch, 1'b1); chk1("s2_ref_stall", stall, 1'b1);
    cyc(); set_in(1, 1, 3'b010, 1, 1, 0, 0);
    #2 chk1("s2_ret_refetch", refetch, 1'b0); chk1("s2_ret_busy", busy, 1'b0);
    chk1("s2_ret_stall", stall, 1'b1);
    cyc(); #2 chk1("s2_nocap_busy", busy, 1'b0);
    cyc(); #2 chk1("s2_cap_busy", busy, 1'b1);
    chk1("s2_one_pulse", (refetch_pulses - rp0) == 1, 1'b1);
    drain_issue_cmplt();
    #2 chk1("s2b_idle", busy, 1'b0);
    cyc();

    // ROB-empty glitch resets the hold count: 1,0,1,1
    set_in(1, 1, 3'b001, 0, 1, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s3_c1_vld", fvld, 1'b0);
    cyc(); set_in(0, 0, 3'b000, 0, 1, 0, 0); #2 chk1("s3_c2_vld", fvld, 1'b0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s3_c3_vld", fvld, 1'b0);
    cyc(); #2 chk1("s3_c4_vld", fvld, 1'b0);
    cyc(); #2 chk1("s3_c5_vld", fvld, 1'b1);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 1, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s3_idle", busy, 1'b0);
    cyc();

    // Backpressure with a type-0 fence, plus a stray cmplt during DRAIN
    set_in(1, 1, 3'b000, 1, 0, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 0, 1, 0); #2 chk1("s4_d1_busy", busy, 1'b1);
    cyc(); set_in(0, 0, 3'b000, 1, 0, 0, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #2 chk1("s4_bp_vld", fvld, 1'b1); chk3("s4_bp_type", ftype, 3'b010);
      cyc();
    end
    set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s4_rdy_vld", fvld, 1'b1);
    cyc(); #2 chk1("s4_wait_vld", fvld, 1'b0); chk1("s4_wait_busy", busy, 1'b1);
    set_in(0, 0, 3'b000, 1, 1, 1, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s4_idle", busy, 1'b0);
    cyc();

    // Multi-hot 3'b101 in WAIT: flush beats cmplt, no refetch, type cleared
    rp0 = refetch_pulses;
    set_in(1, 1, 3'b101, 1, 1, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    cyc(); cyc(); #2 chk3("s5_iss_type", ftype, 3'b101);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 1, 1);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    #2 chk1("s5_busy", busy, 1'b0); chk3("s5_type", ftype, 3'b000); chk1("s5_stall", stall, 1'b0);
    cyc(); #2 chk1("s5_no_refetch", refetch_pulses == rp0, 1'b1);

    // Multi-hot 3'b101 completing normally takes the refetch
    set_in(1, 1, 3'b101, 1, 1, 0, 0);
    cyc(); drain_issue_cmplt();
    #2 chk1("s6_refetch", refetch, 1'b1);
    cyc(); #2 chk1("s6_idle", busy, 1'b0);
    cyc();

    // Flush beats vld&&rdy in ISSUE; flush in IDLE blocks capture
    set_in(1, 1, 3'b100, 1, 1, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    cyc(); cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 1);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0);
    #2 chk1("s7_busy", busy, 1'b0); chk1("s7_vld", fvld, 1'b0);
    cyc(); set_in(1, 1, 3'b010, 1, 1, 0, 1);
    cyc(); set_in(0, 0, 3'b000, 1, 1, 0, 0); #2 chk1("s7_idle_flush", busy, 1'b0);
    cyc();

`ifdef CT_IDU_FENCE_TIMEOUT_EN
    // Watchdog: ROB never empties, counter saturates and error holds until flush
    set_in(1, 1, 3'b010, 0, 1, 0, 0);
    cyc(); set_in(0, 0, 3'b000, 0, 1, 0, 0); #2 chk1("t_start", tmo, 1'b0);
    repeat (18) cyc();
    #2 chk1("t_set", tmo, 1'b1); chk1("t_busy", busy, 1'b1);
    cyc(); #2 chk1("t_hold", tmo, 1'b1);
    set_in(0, 0, 3'b000, 0, 1, 0, 1);
    cyc(); set_in(0, 0, 3'b000, 0, 0, 0, 0);
    #2 chk1("t_clr", tmo, 1'b0); chk1("t_idle", busy, 1'b0);
    cyc();
`endif

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_idu_id_fence_seq.md
Name: ct_idu_id_fence_seq

Overview:
- Sequencer directly downstream of the ID special decoder.
- Consumes the decoded fence indication and 3-bit fence type (bit0 sync/dcache, bit1 CP0/CSR, bit2 fence.i/sfence.vma).
- Serialises each fence: stalls ID, drains the pipeline, issues the fence alone, waits for retire, then (type[2] only) requests a frontend refetch before releasing ID.

Parameters:
- DRAIN_HOLD, 2, consecutive cycles rob_empty must stay high before issue (range 1..7).
- TMO_W, 10, width of optional watchdog counter.

Ports:
- forever_cpuclk  in  1  core clock
- cpurst_b  in  1  reset, asynchronous, active-low
- id_inst_vld  in  1  ID slot holds a valid instruction
- id_fence  in  1  decoded fence indication from special decoder
- id_fence_type  in  3  decoded fence type, one-hot or zero
- rtu_idu_rob_empty  in  1  ROB and all older instructions retired
- rtu_yy_xx_flush  in  1  pipeline flush, highest priority
- ir_fence_rdy  in  1  IR stage accepts issued fence
- rtu_idu_fence_cmplt  in  1  issued fence retired (one-cycle pulse)
- idu_id_stall  out  1  hold ID stage
- idu_ir_fence_vld  out  1  fence issue valid
- idu_ir_fence_type  out  3  latched fence type
- idu_ifu_refetch  out  1  one-cycle frontend refetch request
- fence_seq_busy  out  1  sequencer not IDLE
- fence_seq_tmo  out  1  watchdog error (optional feature only; else tied 0)

Behaviour:
- Reset: state IDLE, type register 0, hold counter 0; all outputs 0.
- States: IDLE, DRAIN, ISSUE, WAIT, REFETCH.
- IDLE: id_inst_vld && id_fence -> latch id_fence_type, go DRAIN, idu_id_stall=1 the same cycle (combinational from inputs).
- DRAIN: hold counter increments while rob_empty=1, clears to 0 when rob_empty=0; saturates at DRAIN_HOLD; counter reaching DRAIN_HOLD -> ISSUE.
- ISSUE: idu_ir_fence_vld=1, type stable; vld stays high until ir_fence_rdy; transfer on vld&&rdy -> WAIT.
- WAIT: rtu_idu_fence_cmplt -> REFETCH if latched type[2], else IDLE.
- REFETCH: idu_ifu_refetch=1 exactly one cycle -> IDLE.
- idu_id_stall=1 in all states except IDLE; in IDLE it equals id_inst_vld&&id_fence.
- ID releases the cycle after return to IDLE.
- A fence in ID on the IDLE-return cycle is not restarted until the following cycle; no back-to-back capture.
- Fence in ISSUE/WAIT is not re-captured from ID (ID is stalled).
- Flush in any state -> IDLE next cycle; counter and type cleared; outputs drop next cycle. Flush dominates a same-cycle cmplt or vld&&rdy.
- cmplt outside WAIT: ignored.
- Multi-hot id_fence_type: latched as-is; refetch taken if bit2 set.
- id_fence with type 0: treated as bit1 (CP0) serialisation.
- fence_seq_busy = (state != IDLE).

Optional Feature:
- Macro CT_IDU_FENCE_TIMEOUT_EN.
- Defined: TMO_W-bit counter, cleared on entering DRAIN or WAIT, increments each cycle in those states, saturates at all-ones. On saturation fence_seq_tmo asserts and holds until flush or reset; state machine unaffected.
- Undefined: no counter; fence_seq_tmo tied 0.

Decomposition:
- Shared package ct_idu_fence_pkg holds:
  - state encoding constants (3-bit: IDLE=0, DRAIN=1, ISSUE=2, WAIT=3, REFETCH=4);
  - fence-type bit index constants (SYNC=0, CP0=1, IFENCE=2);
  - DRAIN_HOLD default.
- One natural sub-module: ct_idu_fence_drain_cnt, the saturating ROB-empty hold counter with clear.

Test Plan:
- CP0 fence: type=3'b010, rob_empty high from cycle 1, rdy=1 -> ISSUE after 2 cycles, vld 1 cycle, cmplt -> IDLE, no refetch, stall drops next cycle.
- fence.i: type=3'b100 -> after cmplt, refetch pulses exactly 1 cycle, then IDLE.
- Drain glitch: rob_empty 1,0,1,1 -> counter resets on 0; ISSUE entered only after 2 consecutive highs.
- Backpressure: ir_fence_rdy low 5 cycles -> vld held 5+ cycles with constant type; WAIT entered on the rdy cycle.
- Flush in WAIT concurrent with cmplt -> IDLE next cycle, no refetch, type register 0.
- With CT_IDU_FENCE_TIMEOUT_EN, TMO_W=4: rob_empty held 0 for 15 cycles -> fence_seq_tmo=1 and held until flush.
